// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the data memory between the MEM stage and a word-burst DMA engine.
// Define DMEM_ARB_FAIRNESS_EN to add a starve counter that forces DMA grants under CPU pressure.
module dmem_port_arbiter #(
  parameter int MEM_BYTES    = 1024,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  output logic        cpu_rvalid,
  input  logic        dma_start,
  input  logic        dma_we,
  input  logic [31:0] dma_base,
  input  logic [7:0]  dma_len,
  input  logic [31:0] dma_wdata,
  output logic        dma_wready,
  output logic [31:0] dma_rdata,
  output logic        dma_rvalid,
  output logic        dma_busy,
  output logic        dma_done,
  output logic        dma_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t      state_q, state_d;
  logic [31:0] burst_addr_q, burst_addr_d;
  logic [7:0]  remaining_q, remaining_d;
  logic        burst_we_q, burst_we_d, done_q, done_d;
  logic        tag_v_q, tag_v_d, tag_dma_q, tag_dma_d;
  logic        burst, cpu_grant, dma_grant, start_try, start_bad, start_ok;
  logic [32:0] burst_end;
  assign burst     = state_q == BURST;
  assign burst_end = {1'b0, dma_base} + {23'd0, dma_len, 2'b00};
  assign start_try = ~reset & dma_start & ~burst & (dma_len != 8'd0);
  assign start_bad = (dma_base[1:0] != 2'b00) | (burst_end > 33'(MEM_BYTES));
  assign start_ok  = start_try & ~start_bad;
`ifdef DMEM_ARB_FAIRNESS_EN
  logic [2:0] starve_q, starve_d;
  assign cpu_grant = ~reset & cpu_req & ~(burst & (starve_q >= 3'(STARVE_LIMIT)));
  always_comb starve_d = dma_grant ? 3'd0 : (burst & cpu_req) ? starve_q + 3'd1 : starve_q;
  always_ff @(posedge clk) starve_q <= reset ? 3'd0 : starve_d;
`else
  assign cpu_grant = ~reset & cpu_req;
`endif
  assign dma_grant = ~reset & burst & ~cpu_grant;
  always_comb begin
    state_d      = state_q;
    burst_addr_d = burst_addr_q;
    remaining_d  = remaining_q;
    burst_we_d   = burst_we_q;
    if (start_ok) begin
      state_d      = BURST;
      burst_addr_d = dma_base;
      remaining_d  = dma_len;
      burst_we_d   = dma_we;
    end else if (dma_grant) begin
      state_d      = (remaining_q == 8'd1) ? IDLE : BURST;
      burst_addr_d = burst_addr_q + 32'd4;
      remaining_d  = remaining_q - 8'd1;
    end
    done_d    = dma_grant & (remaining_q == 8'd1);
    tag_v_d   = mem_read;
    tag_dma_d = dma_grant;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      burst_addr_q <= '0;
      remaining_q  <= '0;
      burst_we_q   <= 1'b0;
      done_q       <= 1'b0;
      tag_v_q      <= 1'b0;
      tag_dma_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_addr_q <= burst_addr_d;
      remaining_q  <= remaining_d;
      burst_we_q   <= burst_we_d;
      done_q       <= done_d;
      tag_v_q      <= tag_v_d;
      tag_dma_q    <= tag_dma_d;
    end
  end
  assign mem_addr   = cpu_grant ? cpu_addr : dma_grant ? burst_addr_q : '0;
  assign mem_wdata  = cpu_grant ? cpu_wdata : dma_grant ? dma_wdata : '0;
  assign mem_write  = (cpu_grant & cpu_we) | (dma_grant & burst_we_q);
  assign mem_read   = (cpu_grant & ~cpu_we) | (dma_grant & ~burst_we_q);
  assign cpu_stall  = ~reset & cpu_req & ~cpu_grant;
  assign dma_wready = dma_grant & burst_we_q;
  assign dma_err    = start_try & start_bad;
  assign dma_busy   = burst;
  assign dma_done   = done_q;
  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = mem_rdata;
  assign cpu_rvalid = tag_v_q & ~tag_dma_q;
  assign dma_rvalid = tag_v_q & tag_dma_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed tests of the data-memory port arbiter against a registered-read memory.
module tb_dmem_port_arbiter;
  logic        clk = 1'b0, reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dma_start = 1'b0, dma_we = 1'b0;
  logic [31:0] dma_base = '0, dma_wdata = '0;
  logic [7:0]  dma_len = '0;
  logic        dma_wready, dma_rvalid, dma_busy, dma_done, dma_err;
  logic [31:0] dma_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read;
  logic [31:0] mem [0:255];
  int cmp = 0, err = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dma_start(dma_start), .dma_we(dma_we), .dma_base(dma_base), .dma_len(dma_len),
    .dma_wdata(dma_wdata), .dma_wready(dma_wready), .dma_rdata(dma_rdata),
    .dma_rvalid(dma_rvalid), .dma_busy(dma_busy), .dma_done(dma_done), .dma_err(dma_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
    if (mem_read) mem_rdata <= mem[mem_addr[9:2]];
  end

  task automatic test_reset;
    reset = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40;
    repeat (2) @(negedge clk);
    #1;
    cmp++; if (mem_write !== 1'b0) begin err++; $display("FAIL reset_mem_write: got %b want 0", mem_write); end
    cmp++; if (cpu_stall !== 1'b0) begin err++; $display("FAIL reset_stall: got %b want 0", cpu_stall); end
    cmp++; if (mem_addr !== 32'h0) begin err++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    cmp++; if ({dma_busy, dma_done, cpu_rvalid, dma_rvalid, dma_err} !== 5'b0) begin
      err++; $display("FAIL reset_outputs: got %b want 00000", {dma_busy, dma_done, cpu_rvalid, dma_rvalid, dma_err}); end
    @(negedge clk);
    reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic test_cpu_store_load;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    #1;
    cmp++; if (cpu_stall !== 1'b0) begin err++; $display("FAIL store_stall: got %b want 0", cpu_stall); end
    cmp++; if ({mem_write, mem_read} !== 2'b10) begin err++; $display("FAIL store_cmd: got %b want 10", {mem_write, mem_read}); end
    cmp++; if (mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF) begin
      err++; $display("FAIL store_bus: got %h/%h want 00000010/deadbeef", mem_addr, mem_wdata); end
    @(negedge clk);
    cpu_we = 1'b0;
    #1;
    cmp++; if (cpu_stall !== 1'b0) begin err++; $display("FAIL load_stall: got %b want 0", cpu_stall); end
    cmp++; if ({mem_write, mem_read} !== 2'b01) begin err++; $display("FAIL load_cmd: got %b want 01", {mem_write, mem_read}); end
    @(negedge clk);
    cpu_we = 1'b1; cpu_addr = 32'h10C; cpu_wdata = 32'hA3;
    #1;
    cmp++; if (cpu_rvalid !== 1'b1 || dma_rvalid !== 1'b0) begin
      err++; $display("FAIL load_rvalid: got cpu %b dma %b want 1 0", cpu_rvalid, dma_rvalid); end
    cmp++; if (cpu_rdata !== 32'hDEADBEEF) begin err++; $display("FAIL load_rdata: got %h want deadbeef", cpu_rdata); end
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0;
    #1;
    cmp++; if (cpu_rvalid !== 1'b0) begin err++; $display("FAIL store_no_rvalid: got %b want 0", cpu_rvalid); end
  endtask

  task automatic test_dma_write;
    @(negedge clk);
    dma_start = 1'b1; dma_we = 1'b1; dma_base = 32'h100; dma_len = 8'd3;
    #1;
    cmp++; if ({dma_err, dma_busy, mem_write} !== 3'b000) begin
      err++; $display("FAIL wr_start: got err/busy/write %b want 000", {dma_err, dma_busy, mem_write}); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dma_start = 1'b0; dma_wdata = 32'hA0 + 32'(i);
      #1;
      cmp++; if ({dma_busy, dma_wready, mem_write, dma_done} !== 4'b1110) begin
        err++; $display("FAIL wr_beat%0d_ctl: got %b want 1110", i, {dma_busy, dma_wready, mem_write, dma_done}); end
      cmp++; if (mem_addr !== 32'h100 + 32'(4 * i) || mem_wdata !== 32'hA0 + 32'(i)) begin
        err++; $display("FAIL wr_beat%0d_bus: got %h/%h want %h/%h", i, mem_addr, mem_wdata, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i)); end
    end
    @(negedge clk);
    #1;
    cmp++; if ({dma_done, dma_busy, dma_wready} !== 3'b100) begin
      err++; $display("FAIL wr_done: got done/busy/wready %b want 100", {dma_done, dma_busy, dma_wready}); end
    @(negedge clk);
    #1;
    cmp++; if (dma_done !== 1'b0) begin err++; $display("FAIL wr_done_pulse: got %b want 0", dma_done); end
  endtask

  task automatic test_dma_read_contended;
    logic [31:0] ea [1:7] = '{32'h100, 32'h10, 32'h10, 32'h104, 32'h108, 32'h10C, 32'h0};
    logic [6:0]  edv = 7'b1110010;
    logic [6:0]  ecv = 7'b0001100;
    logic [31:0] ed  [1:7] = '{32'h0, 32'hA0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hA1, 32'hA2, 32'hA3};
    int pulses = 0;
    @(negedge clk);
    dma_start = 1'b1; dma_we = 1'b0; dma_base = 32'h100; dma_len = 8'd4;
    cpu_we = 1'b0; cpu_addr = 32'h10;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      dma_start = 1'b0; cpu_req = (c == 2 || c == 3);
      #1;
      if (dma_rvalid === 1'b1) pulses++;
      cmp++; if (mem_addr !== ea[c] || mem_read !== (c <= 6) || cpu_stall !== 1'b0) begin
        err++; $display("FAIL rd_c%0d_cmd: got addr %h read %b stall %b want %h %b 0", c, mem_addr, mem_read, cpu_stall, ea[c], c <= 6); end
      cmp++; if (dma_rvalid !== edv[c-1] || cpu_rvalid !== ecv[c-1]) begin
        err++; $display("FAIL rd_c%0d_rvalid: got dma %b cpu %b want %b %b", c, dma_rvalid, cpu_rvalid, edv[c-1], ecv[c-1]); end
      if (c > 1) begin
        cmp++; if (dma_rdata !== ed[c]) begin err++; $display("FAIL rd_c%0d_data: got %h want %h", c, dma_rdata, ed[c]); end
      end
      cmp++; if (dma_busy !== (c <= 6) || dma_done !== (c == 7)) begin
        err++; $display("FAIL rd_c%0d_state: got busy %b done %b want %b %b", c, dma_busy, dma_done, c <= 6, c == 7); end
    end
    cmp++; if (pulses != 4) begin err++; $display("FAIL rd_pulses: got %0d want 4", pulses); end
  endtask

  task automatic test_bad_starts;
    @(negedge clk);
    dma_start = 1'b1; dma_we = 1'b0; dma_base = 32'h102; dma_len = 8'd1;
    #1;
    cmp++; if (dma_err !== 1'b1) begin err++; $display("FAIL err_misaligned: got %b want 1", dma_err); end
    @(negedge clk);
    dma_base = 32'h3FC; dma_len = 8'd2;
    #1;
    cmp++; if (dma_err !== 1'b1 || dma_busy !== 1'b0) begin
      err++; $display("FAIL err_range: got err %b busy %b want 1 0", dma_err, dma_busy); end
    @(negedge clk);
    dma_base = 32'h0; dma_len = 8'd0;
    #1;
    cmp++; if (dma_err !== 1'b0 || dma_busy !== 1'b0) begin
      err++; $display("FAIL len0_silent: got err %b busy %b want 0 0", dma_err, dma_busy); end
    @(negedge clk);
    dma_start = 1'b0;
    #1;
    cmp++; if (dma_err !== 1'b0 || dma_busy !== 1'b0) begin
      err++; $display("FAIL len0_idle: got err %b busy %b want 0 0", dma_err, dma_busy); end
    @(negedge clk);
    dma_start = 1'b1; dma_base = 32'h3FC; dma_len = 8'd1;
    #1;
    cmp++; if (dma_err !== 1'b0) begin err++; $display("FAIL edge_legal: got %b want 0", dma_err); end
    @(negedge clk);
    dma_base = 32'h102;
    #1;
    cmp++; if (dma_busy !== 1'b1 || mem_addr !== 32'h3FC || mem_read !== 1'b1 || dma_err !== 1'b0) begin
      err++; $display("FAIL edge_beat: got busy %b addr %h read %b err %b want 1 3fc 1 0", dma_busy, mem_addr, mem_read, dma_err); end
    @(negedge clk);
    dma_start = 1'b0;
    #1;
    cmp++; if (dma_busy !== 1'b0 || dma_done !== 1'b1 || dma_rvalid !== 1'b1) begin
      err++; $display("FAIL edge_end: got busy %b done %b rvalid %b want 0 1 1", dma_busy, dma_done, dma_rvalid); end
  endtask

  task automatic test_reset_mid_burst;
    @(negedge clk);
    dma_start = 1'b1; dma_we = 1'b1; dma_base = 32'h200; dma_len = 8'd8; dma_wdata = 32'h55;
    @(negedge clk);
    dma_start = 1'b0;
    #1;
    cmp++; if (mem_addr !== 32'h200 || dma_wready !== 1'b1) begin
      err++; $display("FAIL mid_first: got addr %h wready %b want 200 1", mem_addr, dma_wready); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    cmp++; if (mem_write !== 1'b0 || dma_wready !== 1'b0 || cpu_stall !== 1'b0) begin
      err++; $display("FAIL mid_reset_high: got write %b wready %b stall %b want 0 0 0", mem_write, dma_wready, cpu_stall); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    cmp++; if (dma_busy !== 1'b0 || dma_done !== 1'b0 || mem_write !== 1'b0) begin
      err++; $display("FAIL mid_after: got busy %b done %b write %b want 0 0 0", dma_busy, dma_done, mem_write); end
    @(negedge clk);
    #1;
    cmp++; if (dma_done !== 1'b0) begin err++; $display("FAIL mid_no_done: got %b want 0", dma_done); end
    @(negedge clk);
    dma_start = 1'b1; dma_base = 32'h300; dma_len = 8'd1;
    @(negedge clk);
    dma_start = 1'b0;
    #1;
    cmp++; if (mem_addr !== 32'h300 || mem_write !== 1'b1 || dma_busy !== 1'b1) begin
      err++; $display("FAIL mid_restart: got addr %h write %b busy %b want 300 1 1", mem_addr, mem_write, dma_busy); end
    @(negedge clk);
    #1;
    cmp++; if (dma_done !== 1'b1) begin err++; $display("FAIL mid_restart_done: got %b want 1", dma_done); end
  endtask

`ifdef DMEM_ARB_FAIRNESS_EN
  task automatic test_fairness;
    @(negedge clk);
    dma_start = 1'b1; dma_we = 1'b0; dma_base = 32'h100; dma_len = 8'd2;
    cpu_we = 1'b0; cpu_addr = 32'h10;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      dma_start = 1'b0; cpu_req = 1'b1;
      #1;
      cmp++; if (cpu_stall !== (c == 5 || c == 10) ||
                 mem_addr !== ((c == 5) ? 32'h100 : (c == 10) ? 32'h104 : 32'h10)) begin
        err++; $display("FAIL fair_c%0d: got stall %b addr %h", c, cpu_stall, mem_addr); end
    end
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    cmp++; if (dma_done !== 1'b1) begin err++; $display("FAIL fair_done: got %b want 1", dma_done); end
  endtask
`endif

  initial begin
    test_reset;
    test_cpu_store_load;
    test_dma_write;
    test_dma_read_contended;
    test_bad_starts;
    test_reset_mid_burst;
`ifdef DMEM_ARB_FAIRNESS_EN
    test_fairness;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
